// File: rtl/eth_pcs_rx_block_lock.sv
// 64b/66b receive block-lock state machine: hunts for sync-header alignment by
// requesting gearbox slips, then monitors header error rate while locked.
module eth_pcs_rx_block_lock #(
    parameter int SH_VAL_TH    = 64,
    parameter int SH_INVAL_TH  = 16,
    parameter int SLIP_HOLDOFF = 4,
    parameter int W_ERR_CNT    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_signal_ok,
    input  logic                 i_hdr_valid,
    input  logic [1:0]           i_sync,
    input  logic                 i_cnt_clr,
    output logic                 o_block_lock,
    output logic                 o_slip,
    output logic [W_ERR_CNT-1:0] o_hdr_err_cnt,
    output logic [W_ERR_CNT-1:0] o_lock_loss_cnt
);
    localparam int SH_CW  = $clog2(SH_VAL_TH + 1);
    localparam int INV_CW = $clog2(SH_INVAL_TH + 1);
    localparam logic [SH_CW-1:0]  VAL_TH   = SH_VAL_TH[SH_CW-1:0];
    localparam logic [INV_CW-1:0] INVAL_TH = SH_INVAL_TH[INV_CW-1:0];
    localparam logic [7:0]        HOLD     = SLIP_HOLDOFF[7:0];

    typedef enum logic [1:0] {UNLOCK_TEST, SLIP_WAIT, LOCKED, LOCKED_TEST} state_e;

    state_e               state_q, state_d;
    logic [SH_CW-1:0]     sh_cnt_q, sh_cnt_d;
    logic [INV_CW-1:0]    sh_inv_cnt_q, sh_inv_cnt_d;
    logic [7:0]           hold_cnt_q, hold_cnt_d;
    logic                 lock_q, lock_d;
    logic                 slip_q, slip_d;
    logic [W_ERR_CNT-1:0] err_cnt_q, err_cnt_d;
    logic [W_ERR_CNT-1:0] loss_cnt_q, loss_cnt_d;

    logic                 hdr_ok;
    logic [SH_CW-1:0]     sh_cnt_inc;
    logic [INV_CW-1:0]    sh_inv_inc;

    assign hdr_ok     = (i_sync == 2'b01) || (i_sync == 2'b10);
    assign sh_cnt_inc = sh_cnt_q + 1'b1;
    assign sh_inv_inc = hdr_ok ? sh_inv_cnt_q : sh_inv_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        sh_cnt_d     = sh_cnt_q;
        sh_inv_cnt_d = sh_inv_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        lock_d       = lock_q;
        slip_d       = 1'b0;
        err_cnt_d    = err_cnt_q;
        loss_cnt_d   = loss_cnt_q;

        if (!i_signal_ok) begin
            state_d      = UNLOCK_TEST;
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
            hold_cnt_d   = '0;
            lock_d       = 1'b0;
            if (lock_q && loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
        end else begin
            case (state_q)
                UNLOCK_TEST: if (i_hdr_valid) begin
                    if (!hdr_ok) begin
                        state_d      = SLIP_WAIT;
                        sh_cnt_d     = '0;
                        sh_inv_cnt_d = '0;
                        hold_cnt_d   = '0;
                        slip_d       = 1'b1;
                    end else if (sh_cnt_inc == VAL_TH) begin
                        state_d      = LOCKED;
                        sh_cnt_d     = '0;
                        sh_inv_cnt_d = '0;
                        lock_d       = 1'b1;
                    end else begin
                        sh_cnt_d     = sh_cnt_inc;
                    end
                end
                SLIP_WAIT: begin
                    // Headers arriving while the gearbox realigns are discarded
                    if (HOLD == 8'd0) begin
                        state_d = UNLOCK_TEST;
                    end else if (i_hdr_valid) begin
                        if (hold_cnt_q + 8'd1 == HOLD) begin
                            state_d    = UNLOCK_TEST;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 8'd1;
                        end
                    end
                end
                default: if (i_hdr_valid) begin
                    if (!hdr_ok && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    // Lock loss wins over a window completing on the same header
                    if (sh_inv_inc == INVAL_TH) begin
                        state_d      = SLIP_WAIT;
                        sh_cnt_d     = '0;
                        sh_inv_cnt_d = '0;
                        hold_cnt_d   = '0;
                        lock_d       = 1'b0;
                        slip_d       = 1'b1;
                        if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
                    end else if (sh_cnt_inc == VAL_TH) begin
                        state_d      = LOCKED;
                        sh_cnt_d     = '0;
                        sh_inv_cnt_d = '0;
                    end else begin
                        state_d      = LOCKED_TEST;
                        sh_cnt_d     = sh_cnt_inc;
                        sh_inv_cnt_d = sh_inv_inc;
                    end
                end
            endcase
        end

        if (i_cnt_clr) begin
            err_cnt_d  = '0;
            loss_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= UNLOCK_TEST;
            sh_cnt_q     <= '0;
            sh_inv_cnt_q <= '0;
            hold_cnt_q   <= '0;
            lock_q       <= 1'b0;
            slip_q       <= 1'b0;
            err_cnt_q    <= '0;
            loss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sh_cnt_q     <= sh_cnt_d;
            sh_inv_cnt_q <= sh_inv_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            lock_q       <= lock_d;
            slip_q       <= slip_d;
            err_cnt_q    <= err_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    // Signal loss drops lock/slip immediately rather than one cycle later
    assign o_block_lock    = lock_q & i_signal_ok;
    assign o_slip          = slip_q & i_signal_ok;
    assign o_hdr_err_cnt   = err_cnt_q;
    assign o_lock_loss_cnt = loss_cnt_q;
endmodule

// File: tb/tb_eth_pcs_rx_block_lock.sv
// Directed bench for eth_pcs_rx_block_lock: default instance plus a narrow
// counter / raised-threshold instance sharing the same stimulus.
module tb_eth_pcs_rx_block_lock;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        signal_ok = 1'b1;
    logic        hdr_valid = 1'b0;
    logic [1:0]  sync = 2'b01;
    logic        cnt_clr = 1'b0;
    logic        lock, slip;
    logic [15:0] err_cnt, loss_cnt;
    logic        lock2, slip2;
    logic [3:0]  err_cnt2, loss_cnt2;

    int n_tests = 0;
    int n_fail  = 0;
    int slip_seen = 0;
    int slip_pairs = 0;
    logic slip_prev = 1'b0;

    always #5 clk = ~clk;

    eth_pcs_rx_block_lock dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_signal_ok(signal_ok),
        .i_hdr_valid(hdr_valid), .i_sync(sync), .i_cnt_clr(cnt_clr),
        .o_block_lock(lock), .o_slip(slip),
        .o_hdr_err_cnt(err_cnt), .o_lock_loss_cnt(loss_cnt)
    );

    eth_pcs_rx_block_lock #(.SH_INVAL_TH(32), .W_ERR_CNT(4)) dut_narrow (
        .i_clk(clk), .i_rst_n(rst_n), .i_signal_ok(signal_ok),
        .i_hdr_valid(hdr_valid), .i_sync(sync), .i_cnt_clr(cnt_clr),
        .o_block_lock(lock2), .o_slip(slip2),
        .o_hdr_err_cnt(err_cnt2), .o_lock_loss_cnt(loss_cnt2)
    );

    always @(negedge clk) begin
        if (slip) slip_seen++;
        if (slip && slip_prev) slip_pairs++;
        slip_prev = slip;
    end

    // Caller sits at a negedge; returns at the next negedge with outputs settled
    task automatic send(input logic [1:0] s);
        hdr_valid = 1'b1;
        sync = s;
        @(negedge clk);
        hdr_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [1:0] s);
        for (int i = 0; i < n; i++) send(s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        signal_ok = 1'b1;
        cnt_clr = 1'b0;
        hdr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        slip_seen = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({lock, slip, err_cnt, loss_cnt} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got lock=%b slip=%b err=%0d loss=%0d, want all 0", lock, slip, err_cnt, loss_cnt);
        end
        send_n(5, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (lock !== 1'b0 || slip !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got lock=%b slip=%b, want 0 0", lock, slip);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_n(59, 2'b10);
        n_tests++;
        if (lock !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: got lock=%b after 59 post-reset headers, want 0", lock);
        end
        send_n(5, 2'b10);
        n_tests++;
        if (lock !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_relock: got lock=%b after 64 post-reset headers, want 1", lock);
        end
    endtask

    task automatic test_lock_acquire();
        do_reset();
        send_n(63, 2'b01);
        n_tests++;
        if (lock !== 1'b0) begin
            n_fail++;
            $display("FAIL acquire_63: got lock=%b, want 0", lock);
        end
        send(2'b10);
        n_tests++;
        if (lock !== 1'b1 || slip_seen != 0) begin
            n_fail++;
            $display("FAIL acquire_64: got lock=%b slips=%0d, want lock=1 slips=0", lock, slip_seen);
        end
    endtask

    task automatic test_slip();
        do_reset();
        send_n(10, 2'b01);
        send(2'b11);
        n_tests++;
        if (slip !== 1'b1) begin
            n_fail++;
            $display("FAIL slip_pulse: got slip=%b, want 1", slip);
        end
        send(2'b00);
        n_tests++;
        if (slip !== 1'b0) begin
            n_fail++;
            $display("FAIL slip_width: got slip=%b one cycle later, want 0", slip);
        end
        send(2'b01);
        send(2'b11);
        send(2'b10);
        send_n(63, 2'b01);
        n_tests++;
        if (lock !== 1'b0 || slip_seen != 1) begin
            n_fail++;
            $display("FAIL slip_holdoff: got lock=%b slips=%0d after 63 valid, want lock=0 slips=1", lock, slip_seen);
        end
        send(2'b01);
        n_tests++;
        if (lock !== 1'b1) begin
            n_fail++;
            $display("FAIL slip_relock: got lock=%b after 64 valid, want 1", lock);
        end
    endtask

    // Relies on being locked at a fresh window boundary
    task automatic test_locked_errors();
        for (int i = 0; i < 64; i++) send((i % 4 == 0 && i < 60) ? 2'b00 : 2'b01);
        n_tests++;
        if (lock !== 1'b1 || err_cnt !== 16'd15 || loss_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL err_15_window: got lock=%b err=%0d loss=%0d, want 1 15 0", lock, err_cnt, loss_cnt);
        end
        send(2'b11);
        n_tests++;
        if (lock !== 1'b1 || err_cnt !== 16'd16) begin
            n_fail++;
            $display("FAIL err_next_window: got lock=%b err=%0d, want 1 16", lock, err_cnt);
        end
        send_n(63, 2'b10);
    endtask

    task automatic test_lock_loss();
        send_n(15, 2'b11);
        n_tests++;
        if (lock !== 1'b1 || slip !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_15: got lock=%b slip=%b, want 1 0", lock, slip);
        end
        send(2'b00);
        n_tests++;
        if (lock !== 1'b0 || slip !== 1'b1 || loss_cnt !== 16'd1 || err_cnt !== 16'd32) begin
            n_fail++;
            $display("FAIL loss_16: got lock=%b slip=%b loss=%0d err=%0d, want 0 1 1 32", lock, slip, loss_cnt, err_cnt);
        end
        @(negedge clk);
        n_tests++;
        if (slip !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_slip_width: got slip=%b, want 0", slip);
        end
    endtask

    task automatic test_signal_ok();
        send_n(4, 2'b01);
        send_n(64, 2'b01);
        n_tests++;
        if (lock !== 1'b1) begin
            n_fail++;
            $display("FAIL sig_prelock: got lock=%b, want 1", lock);
        end
        slip_seen = 0;
        signal_ok = 1'b0;
        #1;
        n_tests++;
        if (lock !== 1'b0) begin
            n_fail++;
            $display("FAIL sig_drop_lock: got lock=%b, want 0", lock);
        end
        repeat (3) @(negedge clk);
        signal_ok = 1'b1;
        n_tests++;
        if (loss_cnt !== 16'd2 || slip_seen != 0) begin
            n_fail++;
            $display("FAIL sig_drop_count: got loss=%0d slips=%0d, want 2 0", loss_cnt, slip_seen);
        end
        send_n(63, 2'b10);
        n_tests++;
        if (lock !== 1'b0) begin
            n_fail++;
            $display("FAIL sig_relock_63: got lock=%b, want 0", lock);
        end
        send(2'b10);
        n_tests++;
        if (lock !== 1'b1 || loss_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL sig_relock_64: got lock=%b loss=%0d, want 1 2", lock, loss_cnt);
        end
    endtask

    task automatic test_cnt_clr();
        cnt_clr = 1'b1;
        send(2'b11);
        cnt_clr = 1'b0;
        n_tests++;
        if (err_cnt !== 16'd0 || loss_cnt !== 16'd0 || lock !== 1'b1) begin
            n_fail++;
            $display("FAIL cnt_clr: got err=%0d loss=%0d lock=%b, want 0 0 1", err_cnt, loss_cnt, lock);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        send_n(64, 2'b01);
        send_n(20, 2'b00);
        n_tests++;
        if (err_cnt2 !== 4'd15 || lock2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_err: got err=%0d lock=%b, want 15 1", err_cnt2, lock2);
        end
        cnt_clr = 1'b1;
        send(2'b11);
        cnt_clr = 1'b0;
        n_tests++;
        if (err_cnt2 !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_clr_wins: got err=%0d, want 0", err_cnt2);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_lock_acquire();
        test_slip();
        test_locked_errors();
        test_lock_loss();
        test_signal_ok();
        test_cnt_clr();
        test_saturate();
        n_tests++;
        if (slip_pairs != 0) begin
            n_fail++;
            $display("FAIL slip_back_to_back: got %0d consecutive slip cycles, want 0", slip_pairs);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/eth_pcs_rx_block_lock.md
ETH_PCS_RX_BLOCK_LOCK -- requirements
Module: eth_pcs_rx_block_lock

Interface
REQ-001 SHALL have parameter SH_VAL_TH, default 64: number of headers per test window.
REQ-002 SHALL have parameter SH_INVAL_TH, default 16: invalid headers per window that cause lock loss.
REQ-003 SHALL have parameter SLIP_HOLDOFF, default 4: headers ignored after each slip while the gearbox realigns; legal range 0..255.
REQ-004 SHALL have parameter W_ERR_CNT, default 16: width of the statistics counters.
REQ-005 SHALL have port i_clk, input, 1: sole clock; all logic is on the rising edge.
REQ-006 SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port i_signal_ok, input, 1: PMA signal detect; low forces unlock.
REQ-008 SHALL have port i_hdr_valid, input, 1: qualifies i_sync for the current cycle.
REQ-009 SHALL have port i_sync, input, 2: received sync header, in transmission order.
REQ-010 SHALL have port i_cnt_clr, input, 1: synchronous clear of the statistics counters.
REQ-011 SHALL have port o_block_lock, output, 1: block lock achieved.
REQ-012 SHALL have port o_slip, output, 1: single-cycle request for a one-bit gearbox slip.
REQ-013 SHALL have port o_hdr_err_cnt, output, W_ERR_CNT: saturating count of invalid headers received while locked.
REQ-014 SHALL have port o_lock_loss_cnt, output, W_ERR_CNT: saturating count of locked-to-unlocked transitions.

Function
REQ-015 A header SHALL be valid when i_sync is 2'b01 or 2'b10, and invalid otherwise; i_sync SHALL be ignored when i_hdr_valid is 0.
REQ-016 The FSM SHALL have four states: UNLOCK_TEST, SLIP_WAIT, LOCKED, LOCKED_TEST.
REQ-017 Window counter sh_cnt (width $clog2(SH_VAL_TH+1)) and invalid counter sh_inv_cnt (width $clog2(SH_INVAL_TH+1)) SHALL increment only on a qualified header.
REQ-018 In UNLOCK_TEST, an invalid header SHALL clear both counters, pulse o_slip on the next cycle, and move the FSM to SLIP_WAIT.
REQ-019 In UNLOCK_TEST, when the SH_VAL_TH-th consecutive valid header is sampled, the FSM SHALL go to LOCKED, set o_block_lock the next cycle, and clear the counters.
REQ-020 In SLIP_WAIT, SLIP_HOLDOFF qualified headers SHALL be discarded, after which the FSM SHALL return to UNLOCK_TEST with counters at 0; if SLIP_HOLDOFF is 0, SLIP_WAIT SHALL last exactly one cycle.
REQ-021 In LOCKED/LOCKED_TEST, each qualified header SHALL advance sh_cnt, and an invalid header SHALL also advance sh_inv_cnt and o_hdr_err_cnt.
REQ-022 If sh_inv_cnt reaches SH_INVAL_TH within a window, the FSM SHALL clear o_block_lock, pulse o_slip, increment o_lock_loss_cnt, and enter SLIP_WAIT, all registered on the cycle after the offending header.
REQ-023 If sh_cnt reaches SH_VAL_TH with sh_inv_cnt < SH_INVAL_TH, both counters SHALL clear and lock SHALL be kept.
REQ-024 If both conditions occur on the same header, lock loss SHALL take priority.
REQ-025 o_slip SHALL never be high on two consecutive cycles.
REQ-026 While i_signal_ok is 0, the FSM SHALL be held in UNLOCK_TEST with counters cleared, o_block_lock=0, and o_slip=0.
REQ-027 If lock is lost through i_signal_ok falling while locked, o_lock_loss_cnt SHALL increment once.
REQ-028 Statistics counters SHALL saturate at all-ones.
REQ-029 i_cnt_clr SHALL zero the statistics counters the next cycle and SHALL win over a coincident increment.

Reset
REQ-030 While i_rst_n is 0, all outputs SHALL be 0 and the FSM SHALL be in UNLOCK_TEST with counters at 0, asynchronously.
REQ-031 Reset deassertion SHALL be used synchronously to i_clk, and the first header may be accepted on the first edge after deassertion.
REQ-032 Reset asserted mid-window or during SLIP_WAIT SHALL discard all progress, with no o_slip emitted.

Verification
REQ-033 64 valid headers after reset (defaults) -> o_block_lock rises the cycle after the 64th header; o_slip stays 0 throughout.
REQ-034 Unlocked, 10 valid headers then one 2'b11 -> o_slip is high for exactly 1 cycle; the next 4 headers (including invalid ones) are ignored; lock requires 64 further valid headers.
REQ-035 Locked, 15 invalid headers spread across one 64-header window -> lock is held, o_hdr_err_cnt=15, o_lock_loss_cnt=0; a 16th invalid header in the next window (counters reset) does not unlock.
REQ-036 Locked, 16 invalid headers within one window -> o_block_lock=0 and one o_slip pulse the cycle after the 16th; o_lock_loss_cnt=1.
REQ-037 Locked, i_signal_ok dropped for 3 cycles -> o_block_lock=0 and o_lock_loss_cnt increments by 1 with no slip; relock after 64 valid headers.
REQ-038 W_ERR_CNT=4 with 20 invalid headers while locked (SH_INVAL_TH raised to 32) -> o_hdr_err_cnt holds at 15; i_cnt_clr coincident with an error -> 0.
